// File: rtl/ftl_req_arb_if.sv
// rtl/ftl_req_arb_if.sv - requester/engine handshake bundle for ftl_req_arb
interface ftl_req_arb_if #(
  parameter int BLK_W = 10
);
  // port 0: SDHC block cache
  logic             r0_read;
  logic             r0_write;
  logic [BLK_W-1:0] r0_block;
  logic             r0_done;
  logic             r0_err;
  // port 1: CPU maintenance/flush path
  logic             r1_read;
  logic             r1_write;
  logic [BLK_W-1:0] r1_block;
  logic             r1_done;
  logic             r1_err;
  // logical block engine
  logic             ftl_read;
  logic             ftl_write;
  logic [BLK_W-1:0] ftl_block;
  logic             ftl_ack;
  logic             ftl_done;
  // status
  logic             busy;
  logic             owner;

  // arbiter side
  modport slave (
    input  r0_read, r0_write, r0_block, r1_read, r1_write, r1_block, ftl_ack, ftl_done,
    output r0_done, r0_err, r1_done, r1_err, ftl_read, ftl_write, ftl_block, busy, owner
  );

  // requesters plus engine side
  modport master (
    output r0_read, r0_write, r0_block, r1_read, r1_write, r1_block, ftl_ack, ftl_done,
    input  r0_done, r0_err, r1_done, r1_err, ftl_read, ftl_write, ftl_block, busy, owner
  );
endinterface

// File: rtl/ftl_req_arb.sv
// rtl/ftl_req_arb.sv - two-port round-robin arbiter/sequencer for the FTL block engine
module ftl_req_arb #(
  parameter int BLK_W   = 10,
  parameter int TMO_W   = 24,
  parameter int TMO_CYC = 10_000_000
) (
  input logic          clk_50,
  input logic          reset,
  ftl_req_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RELEASE} state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  state_t           state;
  logic             last_owner;
  logic             owner_q;
  logic             busy_q;
  logic             rd_q;
  logic             wr_q;
  logic [BLK_W-1:0] blk_q;
  logic             done0_q;
  logic             err0_q;
  logic             done1_q;
  logic             err1_q;
  logic             done_d;
  logic [TMO_W-1:0] wdog;

  logic             pend0;
  logic             pend1;
  logic             grant1;
  logic             sel_write;
  logic [BLK_W-1:0] sel_block;
  logic             own_req;
  logic             done_rise;
  logic             tmo_hit;

  // grant choice, owner's request level, engine completion edge and watchdog expiry
  always_comb begin
    pend0     = bus.r0_read | bus.r0_write;
    pend1     = bus.r1_read | bus.r1_write;
    // a tie goes to whichever port was not served last
    grant1    = pend1 & (~pend0 | ~last_owner);
    sel_write = grant1 ? bus.r1_write : bus.r0_write;
    sel_block = grant1 ? bus.r1_block : bus.r0_block;
    own_req   = owner_q ? pend1 : pend0;
    done_rise = bus.ftl_done & ~done_d;
    tmo_hit   = (wdog == TMO_LAST);
  end

  // sequencer: grant, issue, await completion or watchdog, then wait for the handshake to close
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      owner_q    <= 1'b0;
      busy_q     <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      blk_q      <= '0;
      done0_q    <= 1'b0;
      err0_q     <= 1'b0;
      done1_q    <= 1'b0;
      err1_q     <= 1'b0;
      done_d     <= 1'b0;
      wdog       <= '0;
    end else begin
      done_d  <= bus.ftl_done;
      done0_q <= 1'b0;
      err0_q  <= 1'b0;
      done1_q <= 1'b0;
      err1_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (pend0 | pend1) begin
            owner_q <= grant1;
            rd_q    <= ~sel_write;
            wr_q    <= sel_write;
            blk_q   <= sel_block;
            wdog    <= '0;
            busy_q  <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE, WAIT_DONE: begin
          if (done_rise) begin
            // completion beats a watchdog expiry landing on the same cycle
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            done0_q <= ~owner_q;
            done1_q <= owner_q;
            state   <= RELEASE;
          end else if (tmo_hit) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err0_q  <= ~owner_q;
            err1_q  <= owner_q;
            state   <= RELEASE;
          end else begin
            wdog <= wdog + 1'b1;
            if (state == ISSUE && bus.ftl_ack) begin
              state <= WAIT_DONE;
            end
          end
        end
        RELEASE: begin
          // no new grant until both the engine and the owner have let go
          if (!bus.ftl_ack && !own_req) begin
            last_owner <= owner_q;
            busy_q     <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ftl_read  = rd_q;
  assign bus.ftl_write = wr_q;
  assign bus.ftl_block = blk_q;
  assign bus.r0_done   = done0_q;
  assign bus.r0_err    = err0_q;
  assign bus.r1_done   = done1_q;
  assign bus.r1_err    = err1_q;
  assign bus.busy      = busy_q;
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_ftl_req_arb.sv
// tb/tb_ftl_req_arb.sv - self-checking bench for ftl_req_arb against a transaction-level model
module tb_ftl_req_arb;

  localparam int BLK_W = 10;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   started = 1'b0;
  bit   auto_mode = 1'b0;

  ftl_req_arb_if #(.BLK_W(BLK_W)) bus ();

  ftl_req_arb #(.BLK_W(BLK_W), .TMO_W(8), .TMO_CYC(TMO)) dut (
    .clk_50(clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Externally the arbiter is idle, running one operation, or releasing it.
  int             m_phase = 0;
  int             m_age = 0;
  bit             m_owner, m_last, m_busy, m_rd, m_wr, m_dprev;
  bit             m_d0, m_e0, m_d1, m_e1;
  bit [BLK_W-1:0] m_blk;

  always @(posedge clk) begin
    bit drise, p0, p1, own_req, w;
    drise   = bus.ftl_done && !m_dprev;
    p0      = bus.r0_read || bus.r0_write;
    p1      = bus.r1_read || bus.r1_write;
    own_req = m_owner ? p1 : p0;
    m_d0 = 0; m_e0 = 0; m_d1 = 0; m_e1 = 0;
    if (reset) begin
      m_phase = 0; m_age = 0; m_owner = 0; m_last = 1; m_busy = 0;
      m_rd = 0; m_wr = 0; m_blk = '0; m_dprev = 0;
    end else begin
      m_dprev = bus.ftl_done;
      if (m_phase == 0) begin
        if (p0 || p1) begin
          m_owner = (p0 && p1) ? !m_last : p1;
          w       = m_owner ? bus.r1_write : bus.r0_write;
          m_blk   = m_owner ? bus.r1_block : bus.r0_block;
          m_rd = !w; m_wr = w; m_busy = 1; m_age = 0; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (drise || m_age == TMO - 1) begin
          m_rd = 0; m_wr = 0; m_phase = 2;
          if (drise) begin
            if (m_owner) m_d1 = 1; else m_d0 = 1;
          end else begin
            if (m_owner) m_e1 = 1; else m_e0 = 1;
          end
        end else begin
          m_age++;
        end
      end else if (!bus.ftl_ack && !own_req) begin
        m_phase = 0; m_busy = 0; m_last = m_owner;
      end
    end
    started = 1;
    cyc++;
  end

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    logic [BLK_W+7:0] act, exp;
    if (started) begin
      act = {bus.ftl_read, bus.ftl_write, bus.ftl_block, bus.r0_done, bus.r0_err,
             bus.r1_done, bus.r1_err, bus.busy, bus.owner};
      exp = {m_rd, m_wr, m_blk, m_d0, m_e0, m_d1, m_e1, m_busy, m_owner};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL model_cycle_%0d: rd/wr/blk/d0/e0/d1/e1/busy/owner got %b expected %b", cyc, act, exp);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int p, input bit rd, input bit wr, input logic [BLK_W-1:0] blk);
    if (p == 0) begin
      bus.r0_read = rd; bus.r0_write = wr; bus.r0_block = blk;
    end else begin
      bus.r1_read = rd; bus.r1_write = wr; bus.r1_block = blk;
    end
  endtask

  // ---------------- random engine and requesters ----------------
  int e_st = 0, e_ack_dly = 0, e_done_dly = 0, e_dlen = 0, e_rel = 0;
  bit e_noack = 0;
  bit hold[2];
  int drop[2];

  always @(negedge clk) begin
    bit strobe, seen;
    if (auto_mode) begin
      strobe = bus.ftl_read || bus.ftl_write;
      if (e_dlen > 0) begin bus.ftl_done = 1; e_dlen--; end
      else bus.ftl_done = 0;
      case (e_st)
        0: begin
          if (strobe) begin
            e_ack_dly  = int'($urandom_range(0, 3));
            e_done_dly = int'($urandom_range(0, 6));
            e_rel      = int'($urandom_range(0, 3));
            e_noack    = ($urandom_range(0, 7) == 0);
            e_st = 1;
          end else if (e_dlen == 0 && $urandom_range(0, 40) == 0) begin
            e_dlen = 1;
          end
        end
        1: begin
          if (!strobe) e_st = 3;
          else if (e_ack_dly > 0) e_ack_dly--;
          else begin
            if (!e_noack) bus.ftl_ack = 1;
            e_st = e_noack ? 3 : 2;
          end
        end
        2: begin
          if (!strobe) e_st = 3;
          else if (e_done_dly > 0) e_done_dly--;
          else begin e_dlen = int'($urandom_range(1, 3)); e_st = 3; end
        end
        default: begin
          if (!strobe) begin
            if (e_rel > 0) e_rel--;
            else begin bus.ftl_ack = 0; e_st = 0; end
          end
        end
      endcase
      for (int p = 0; p < 2; p++) begin
        seen = (p == 0) ? (bus.r0_done || bus.r0_err) : (bus.r1_done || bus.r1_err);
        if (hold[p]) begin
          if (drop[p] < 0 && seen) drop[p] = int'($urandom_range(0, 2));
          if (drop[p] == 0) begin
            hold[p] = 0; drop[p] = -1; set_req(p, 0, 0, '0);
          end else if (drop[p] > 0) drop[p]--;
        end else if ($urandom_range(0, 5) == 0) begin
          int k;
          k = int'($urandom_range(0, 3));
          hold[p] = 1; drop[p] = -1;
          set_req(p, k != 2, k >= 2, BLK_W'($urandom_range(0, 1023)));
        end
      end
    end
  end

  // ---------------- directed scenarios then random run ----------------
  initial begin
    set_req(0, 0, 0, '0);
    set_req(1, 0, 0, '0);
    bus.ftl_ack = 0; bus.ftl_done = 0;
    hold[0] = 0; hold[1] = 0; drop[0] = -1; drop[1] = -1;
    tick(); tick();
    reset = 0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_owner", bus.owner, 0);
    chk("rst_strobes", {bus.ftl_read, bus.ftl_write}, 0);

    // single read from port 0
    set_req(0, 1, 0, 5);
    tick();
    chk("t1_read", bus.ftl_read, 1);
    chk("t1_block", bus.ftl_block, 5);
    chk("t1_busy", bus.busy, 1);
    bus.ftl_ack = 1; tick();
    chk("t1_no_early_done", bus.r0_done, 0);
    bus.ftl_done = 1; tick();
    chk("t1_r0_done", bus.r0_done, 1);
    chk("t1_r1_done", bus.r1_done, 0);
    chk("t1_strobe_low", bus.ftl_read, 0);
    bus.ftl_done = 0; bus.ftl_ack = 0; set_req(0, 0, 0, 5); tick();
    chk("t1_pulse_1cyc", bus.r0_done, 0);
    chk("t1_idle", bus.busy, 0);

    // tie after reset: port 0 first; later tie after port 0 served: port 1 first
    reset = 1; tick(); reset = 0;
    set_req(0, 0, 1, 7); set_req(1, 1, 0, 9); tick();
    chk("t2_write", bus.ftl_write, 1);
    chk("t2_block7", bus.ftl_block, 7);
    chk("t2_owner0", bus.owner, 0);
    bus.ftl_ack = 1; tick(); bus.ftl_done = 1; tick();
    chk("t2_r0_done", bus.r0_done, 1);
    bus.ftl_done = 0; bus.ftl_ack = 0; set_req(0, 0, 0, 7); tick();
    chk("t2_release_idle", bus.busy, 0);
    set_req(0, 0, 1, 7); tick();
    chk("t2_owner1", bus.owner, 1);
    chk("t2_read", bus.ftl_read, 1);
    chk("t2_block9", bus.ftl_block, 9);
    bus.ftl_ack = 1; tick(); bus.ftl_done = 1; tick();
    chk("t2_r1_done", bus.r1_done, 1);
    bus.ftl_done = 0; bus.ftl_ack = 0; set_req(1, 0, 0, 9); tick(); tick();
    chk("t2_then_p0", bus.owner, 0);
    chk("t2_then_block7", bus.ftl_block, 7);
    bus.ftl_ack = 1; tick(); bus.ftl_done = 1; tick();
    bus.ftl_done = 0; bus.ftl_ack = 0; set_req(0, 0, 0, 7); tick();

    // read and write both high means write
    set_req(1, 1, 1, 3); tick();
    chk("t3_write", bus.ftl_write, 1);
    chk("t3_read", bus.ftl_read, 0);
    chk("t3_block3", bus.ftl_block, 3);
    bus.ftl_ack = 1; tick(); bus.ftl_done = 1; tick();
    chk("t3_r1_done", bus.r1_done, 1);
    bus.ftl_done = 0; bus.ftl_ack = 0; set_req(1, 0, 0, 3); tick();

    // watchdog expiry with no ack
    set_req(0, 1, 0, 1); tick();
    chk("t4_read", bus.ftl_read, 1);
    repeat (15) tick();
    chk("t4_no_err_yet", bus.r0_err, 0);
    chk("t4_still_issuing", bus.ftl_read, 1);
    tick();
    chk("t4_err", bus.r0_err, 1);
    chk("t4_no_done", bus.r0_done, 0);
    chk("t4_strobe_low", bus.ftl_read, 0);
    tick();
    chk("t4_err_1cyc", bus.r0_err, 0);
    chk("t4_held_release", bus.busy, 1);
    set_req(0, 0, 0, 1); tick();
    chk("t4_idle", bus.busy, 0);

    // reset while waiting for done, then a stray done edge
    set_req(0, 1, 0, 4); tick();
    bus.ftl_ack = 1; tick();
    chk("t5_busy", bus.busy, 1);
    reset = 1; set_req(0, 0, 0, 4); bus.ftl_ack = 0; tick();
    chk("t5_strobe_low", bus.ftl_read, 0);
    chk("t5_busy_low", bus.busy, 0);
    reset = 0; bus.ftl_done = 1; tick();
    chk("t5_no_done", bus.r0_done, 0);
    chk("t5_stay_idle", bus.busy, 0);
    bus.ftl_done = 0; tick();

    // ack held past done keeps RELEASE
    set_req(1, 0, 1, 2); tick();
    bus.ftl_ack = 1; tick(); bus.ftl_done = 1; tick();
    chk("t6_r1_done", bus.r1_done, 1);
    bus.ftl_done = 0; set_req(1, 0, 0, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_release_hold", bus.busy, 1);
    end
    bus.ftl_ack = 0; tick();
    chk("t6_idle", bus.busy, 0);

    // randomized traffic with occasional resets
    auto_mode = 1;
    repeat (4000) begin
      tick();
      reset = ($urandom_range(0, 299) == 0);
    end
    auto_mode = 0;
    reset = 0;
    set_req(0, 0, 0, '0); set_req(1, 0, 0, '0);
    bus.ftl_ack = 0; bus.ftl_done = 0;
    repeat (40) tick();
    chk("end_idle", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
